// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver on the system clock: synchroniser,
// glitch filter, frame decoder with watchdog, and a show-ahead byte FIFO.
module ps2_rx_fifo #(
  parameter int DATA_BITS      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ps2c,
  input  logic                 ps2d,
  input  logic                 rx_en,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_done_tick,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_BITS - 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_N  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [SYNC_STAGES-1:0] c_sync;
  logic [SYNC_STAGES-1:0] d_sync;
  logic                   c_s;
  logic                   d_bit;
  logic                   c_flt;
  logic [FW-1:0]          flt_cnt;
  logic                   fall_tick;

  state_t                 state;
  logic [BW-1:0]          bitcnt;
  logic [DATA_BITS-1:0]   sreg;
  logic [DATA_BITS:0]     sh;
  logic                   par_acc;
  logic [WW-1:0]          wd_cnt;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   pop;
  logic                   push_req;
  logic                   push;

  assign c_s   = c_sync[SYNC_STAGES-1];
  assign d_bit = d_sync[SYNC_STAGES-1];
  assign sh    = {d_bit, sreg};

  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync <= '1;
      d_sync <= '1;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], ps2c};
      d_sync <= {d_sync[SYNC_STAGES-2:0], ps2d};
    end
  end

  // flt_cnt counts consecutive samples disagreeing with c_flt
  always_ff @(posedge clk) begin
    if (reset) begin
      c_flt     <= 1'b1;
      flt_cnt   <= '0;
      fall_tick <= 1'b0;
    end else begin
      fall_tick <= (c_s != c_flt) && (flt_cnt == FLT_MAX) && c_flt;
      if (c_s == c_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_MAX) begin
        c_flt   <= c_s;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bitcnt     <= '0;
      sreg       <= '0;
      par_acc    <= 1'b0;
      wd_cnt     <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE || fall_tick) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (fall_tick) begin
        unique case (state)
          IDLE: begin
            if (!d_bit && rx_en) begin
              state   <= DATA;
              bitcnt  <= '0;
              par_acc <= 1'b0;
            end
          end
          DATA: begin
            sreg    <= sh[DATA_BITS:1];
            par_acc <= par_acc ^ d_bit;
            bitcnt  <= bitcnt + 1'b1;
            if (bitcnt == BIT_MAX) state <= PARITY;
          end
          PARITY: begin
            par_acc <= par_acc ^ d_bit;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!d_bit) begin
              frame_err <= 1'b1;
            end else if (!par_acc) begin
              parity_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && wd_cnt == WD_MAX) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end
    end
  end

  assign push_req = fall_tick && (state == STOP) && d_bit && par_acc;
  assign full     = (count == FULL_N);
  assign pop      = rd_en && (count != '0);
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      rx_done_tick <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      rx_done_tick <= push;
      if (push_req && full && !pop) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign rx_valid = (count != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames, errors, FIFO limits,
// watchdog, glitch rejection, rx_en gating and reset recovery.
module tb_ps2_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic       rd_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_done_tick;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int ncomp = 0;
  int nfail = 0;
  int cyc = 0;
  int done_n = 0;
  int perr_n = 0;
  int ferr_n = 0;
  int last_done = 0;
  int last_fall = 0;
  int lat;
  int d0, p0, f0;

  ps2_rx_fifo #(
    .DATA_BITS(8),
    .FIFO_DEPTH(4),
    .SYNC_STAGES(2),
    .FILTER_LEN(8),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2c(ps2c),
    .ps2d(ps2d),
    .rx_en(rx_en),
    .rd_en(rd_en),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_done_tick(rx_done_tick),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // every high cycle counts, so a stretched pulse shows up as extra
  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_n++;
      last_done = cyc;
    end
    if (parity_err) perr_n++;
    if (frame_err) ferr_n++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    ncomp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2d = bits[i];
      wait_cyc(10);
      ps2c = 1'b0;
      last_fall = cyc;
      wait_cyc(20);
      ps2c = 1'b1;
      wait_cyc(10);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stp);
    send_bits({stp, par, d, 1'b0}, 11);
    wait_cyc(10);
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, ~^d, 1'b1);
  endtask

  task automatic pop_one;
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
    wait_cyc(1);
  endtask

  task automatic expect_head(input string tag, input logic [7:0] d);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, rx_data}, {24'd0, d});
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    rx_en = 1'b1;
    rd_en = 1'b0;
    wait_cyc(3);
    @(negedge clk);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_pulses", {29'd0, rx_done_tick, parity_err, frame_err}, 32'd0);
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(5);

    send_frame(8'hA5, 1'b1, 1'b1);
    check("a5_done", done_n, 1);
    expect_head("a5", 8'hA5);
    pop_one();
    @(negedge clk);
    check("a5_pop", {31'd0, rx_valid}, 32'd0);
    #1;

    send_frame(8'h3C, 1'b0, 1'b1);
    check("3c_perr", perr_n, 1);
    check("3c_done", done_n, 1);
    check("3c_valid", {31'd0, rx_valid}, 32'd0);

    send_frame(8'h55, 1'b1, 1'b0);
    check("55_ferr", ferr_n, 1);
    check("55_perr", perr_n, 1);
    check("55_valid", {31'd0, rx_valid}, 32'd0);
    send_good(8'h12);
    expect_head("12", 8'h12);
    pop_one();

    d0 = done_n;
    for (int i = 1; i <= 4; i++) send_good(8'(i));
    check("fill_done", done_n - d0, 4);
    check("fill_ovf", {31'd0, overflow}, 32'd0);
    send_good(8'h05);
    check("full_ovf", {31'd0, overflow}, 32'd1);
    check("full_done", done_n - d0, 4);
    for (int i = 1; i <= 4; i++) begin
      expect_head("drain", 8'(i));
      pop_one();
    end
    @(negedge clk);
    check("drain_empty", {31'd0, rx_valid}, 32'd0);
    #1;

    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(5);
    check("rst2_ovf", {31'd0, overflow}, 32'd0);
    d0 = done_n;
    for (int i = 1; i <= 4; i++) send_good(8'h10 + 8'(i));
    lat = last_done - last_fall;
    send_bits({1'b1, ~^8'h15, 8'h15, 1'b0}, 10);
    ps2d = 1'b1;
    wait_cyc(10);
    ps2c = 1'b0;
    wait_cyc(lat - 1);
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
    wait_cyc(20 - lat);
    ps2c = 1'b1;
    wait_cyc(20);
    check("pp_done", done_n - d0, 5);
    check("pp_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 2; i <= 5; i++) begin
      expect_head("pp_drain", 8'h10 + 8'(i));
      pop_one();
    end
    @(negedge clk);
    check("pp_empty", {31'd0, rx_valid}, 32'd0);
    #1;

    f0 = ferr_n;
    send_bits(11'b111_0110_1010, 5);
    wait_cyc(1100);
    check("wd_ferr", ferr_n - f0, 1);
    check("wd_valid", {31'd0, rx_valid}, 32'd0);
    send_good(8'hF0);
    expect_head("f0", 8'hF0);
    pop_one();

    d0 = done_n;
    p0 = perr_n;
    f0 = ferr_n;
    ps2d = 1'b0;
    wait_cyc(5);
    ps2c = 1'b0;
    wait_cyc(3);
    ps2c = 1'b1;
    wait_cyc(5);
    ps2d = 1'b1;
    wait_cyc(40);
    check("glitch_pulses", (done_n - d0) + (perr_n - p0) + (ferr_n - f0), 0);
    check("glitch_valid", {31'd0, rx_valid}, 32'd0);
    send_good(8'h33);
    expect_head("33", 8'h33);

    rx_en = 1'b0;
    d0 = done_n;
    send_good(8'h44);
    check("rxen_done", done_n - d0, 0);
    rx_en = 1'b1;
    expect_head("rxen", 8'h33);

    send_bits(11'b111_0000_0000, 6);
    reset = 1'b1;
    wait_cyc(1);
    @(negedge clk);
    check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
    check("mid_rst_data", {24'd0, rx_data}, 32'd0);
    #1;
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(50);
    send_good(8'h7E);
    expect_head("7e", 8'h7E);
    pop_one();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
